mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Multi-cycle MIPS main controller, directly upstream of alu_cu.
- Decodes the instruction opcode and sequences fetch, decode, execute, memory and writeback over several cycles.
- Drives the datapath mux selects and write enables.
- Produces the 2-bit aluop consumed by alu_cu, encoded 0=add, 1=use funct, 2=sub, 3=add.

Parameters:
- none (state encoding and opcodes are fixed below)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instr[31:26] from instruction register; sampled in DECODE
- zero  in  1  ALU zero flag; used in branch states
- mem_ready  in  1  memory handshake; access completes in the cycle it is 1
- pc_en  out  1  PC load enable
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- reg_write  out  1  register file write
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  0=ALUOut, 1=MDR
- alu_src_a  out  1  0=PC, 1=rs
- alu_src_b  out  2  00=rt, 01=const 4, 10=signext imm, 11=signext imm<<2
- pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
- aluop  out  2  to alu_cu
- illegal  out  1  one-cycle pulse on an unrecognised opcode
- state  out  4  current state, for debug and bench

Behaviour:
- Moore FSM with one 4-bit state register. Every output except pc_en and the mem_ready gating is decoded purely from state; any output not listed for a state is 0.
- Async reset: state=IDLE(0) immediately and all outputs 0.
- State encodings: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, ALUWB 8, BEQ 9, ADDIEX 10, ADDIWB 11, JUMP 12, BNE 13.
- IDLE: no outputs asserted; next FETCH unconditionally. This is the first cycle after reset release.
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, aluop=0.
  - ir_write and pc_en asserted only when mem_ready=1; pc_src=00.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, aluop=0. Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXEC
  - 000100 (beq) -> BEQ
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - anything else -> FETCH, with illegal=1 for this one DECODE cycle
- MEMADR: alu_src_a=1, alu_src_b=10, aluop=0. Next MEMRD for lw, MEMWR for sw (opcode held stable by the IR).
- MEMRD: iord=1; waits on mem_ready; next MEMWB when mem_ready=1.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1; next FETCH.
- MEMWR: iord=1, mem_write=1 held for the whole state; next FETCH when mem_ready=1.
- EXEC: alu_src_a=1, alu_src_b=00, aluop=1; next ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1; next FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, aluop=2, pc_src=01, pc_en=zero (combinational); next FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, aluop=0; next ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1; next FETCH.
- JUMP: pc_src=10, pc_en=1; next FETCH.
- Unused encodings (14, 15, and 13 when the feature is off): all outputs 0, illegal=1, next FETCH.
- reg_write, mem_write and pc_en are never asserted together except as listed; reg_write is at most one cycle per instruction.
- Reset asserted mid-instruction: enable outputs drop immediately, no partial write completes, and execution restarts from IDLE.
- Cycle counts with mem_ready tied to 1:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2

Optional Feature:
- Macro: MC_CTRL_BNE_EN.
- When defined: opcode 000101 in DECODE -> BNE(13). BNE drives the same outputs as BEQ except pc_en=~zero; next FETCH.
- When undefined: 000101 is illegal, and state 13 is unreachable and treated as an unused encoding.

Test Plan:
- Reset behaviour: hold rst_n=0 mid-EXEC, then release with mem_ready=1 -> all outputs 0 during reset; state 0 then 1; first ir_write/pc_en pulse is in cycle 2 after release.
- lw with mem_ready=1: state sequence 1,2,3,4,5; aluop=0 in 1/2/3; reg_write=1 only in 5, with mem_to_reg=1 and reg_dst=0.
- R-type followed by sw, with mem_ready low for 3 cycles in FETCH and in MEMWR:
  - FETCH held 4 cycles, ir_write=1 only in the last of them
  - EXEC shows aluop=1
  - mem_write=1 for all 4 MEMWR cycles, then state 1
- beq: zero=1 -> pc_en=1 with pc_src=01 and aluop=2 in state 9; repeat with zero=0 -> pc_en=0; both return to state 1.
- j and opcode 111111:
  - j -> state 12 with pc_en=1, pc_src=10
  - 111111 -> illegal pulse in DECODE, next state 1, no write enables asserted
- With MC_CTRL_BNE_EN, opcode 000101:
  - zero=0 -> state 13, pc_en=1
  - zero=1 -> pc_en=0
  - without the macro -> illegal=1

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main controller. Sequences fetch, decode, execute, memory
// and writeback for lw, sw, R-type, beq, addi and j, and drives the datapath
// mux selects, write enables and the 2-bit aluop for alu_cu
// (0=add, 1=use funct, 2=sub, 3=add).
//
// Optional feature: define MC_CTRL_BNE_EN to decode bne (opcode 000101) into
// state BNE(13). Without it 000101 is illegal and state 13 is an unused code.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset (state -> IDLE, outputs 0)
//   opcode     instr[31:26] from the IR; sampled in DECODE and MEMADR
//   zero       ALU zero flag, used by the branch states
//   mem_ready  memory handshake; an access completes in the cycle it is 1
//   pc_en      PC load enable
//   iord       memory address select: 0=PC, 1=ALUOut
//   mem_write  memory write strobe
//   ir_write   instruction register load
//   reg_write  register file write
//   reg_dst    0=rt, 1=rd
//   mem_to_reg 0=ALUOut, 1=MDR
//   alu_src_a  0=PC, 1=rs
//   alu_src_b  00=rt, 01=4, 10=signext imm, 11=signext imm<<2
//   pc_src     00=ALU result, 01=ALUOut, 10=jump target
//   aluop      operation class for alu_cu
//   illegal    pulse on an unrecognised opcode or unused state encoding
//   state      current state, for debug
module mc_ctrl_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] aluop,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StExec   = 4'd7,
    StAluWb  = 4'd8,
    StBeq    = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11,
    StJump   = 4'd12,
    StBne    = 4'd13
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
`ifdef MC_CTRL_BNE_EN
  localparam logic [5:0] OpBne   = 6'b000101;
`endif

  localparam logic [1:0] AluAdd   = 2'd0;
  localparam logic [1:0] AluFunct = 2'd1;
  localparam logic [1:0] AluSub   = 2'd2;

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    aluop      = AluAdd;
    illegal    = 1'b0;

    case (state_q)
      StIdle: begin
        state_d = StFetch;
      end

      // PC + 4 is computed every FETCH cycle but only committed, together
      // with the IR load, in the cycle memory returns the instruction.
      StFetch: begin
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) begin
          state_d = StDecode;
        end
      end

      // Branch target PC + (imm << 2) is precomputed into ALUOut here.
      StDecode: begin
        alu_src_b = 2'b11;
        case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRType:    state_d = StExec;
          OpBeq:      state_d = StBeq;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
`ifdef MC_CTRL_BNE_EN
          OpBne:      state_d = StBne;
`endif
          default: begin
            state_d = StFetch;
            illegal = 1'b1;
          end
        endcase
      end

      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OpSw) ? StMemWr : StMemRd;
      end

      StMemRd: begin
        iord = 1'b1;
        if (mem_ready) begin
          state_d = StMemWb;
        end
      end

      StMemWb: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = StFetch;
      end

      // Write strobe stays high for the whole access, not just the last cycle.
      StMemWr: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          state_d = StFetch;
        end
      end

      StExec: begin
        alu_src_a = 1'b1;
        aluop     = AluFunct;
        state_d   = StAluWb;
      end

      StAluWb: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = StFetch;
      end

      StBeq: begin
        alu_src_a = 1'b1;
        aluop     = AluSub;
        pc_src    = 2'b01;
        pc_en     = zero;
        state_d   = StFetch;
      end

      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = StAddiWb;
      end

      StAddiWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end

      StJump: begin
        pc_src  = 2'b10;
        pc_en   = 1'b1;
        state_d = StFetch;
      end

`ifdef MC_CTRL_BNE_EN
      StBne: begin
        alu_src_a = 1'b1;
        aluop     = AluSub;
        pc_src    = 2'b01;
        pc_en     = ~zero;
        state_d   = StFetch;
      end
`endif

      // Unused encodings recover to FETCH and flag the event.
      default: begin
        illegal = 1'b1;
        state_d = StFetch;
      end
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_src, aluop;
  logic       illegal;
  logic [3:0] state;

  always #5 clk = ~clk;

  mc_ctrl_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .iord       (iord),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .aluop      (aluop),
    .illegal    (illegal),
    .state      (state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pe;
    logic       iod;
    logic       mw;
    logic       irw;
    logic       rw;
    logic       rd;
    logic       m2r;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] pcs;
    logic [1:0] aop;
    logic       ill;
  } out_t;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpBne  = 6'b000101;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;

  out_t act;
  assign act = '{st: state, pe: pc_en, iod: iord, mw: mem_write, irw: ir_write,
                 rw: reg_write, rd: reg_dst, m2r: mem_to_reg, asa: alu_src_a,
                 asb: alu_src_b, pcs: pc_src, aop: aluop, ill: illegal};

  out_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  task automatic chk(input string n, input out_t got, input out_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h required %h", n, cyc, got, want);
    end
  endtask

  // Monitor: one expected response per clock cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      chk(n, act, e);
    end
  end

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    logic l;
    l = (op == OpLw) || (op == OpSw) || (op == OpR) || (op == OpBeq) ||
        (op == OpAddi) || (op == OpJ);
`ifdef MC_CTRL_BNE_EN
    l = l || (op == OpBne);
`endif
    return l;
  endfunction

  // Drive one clock cycle's inputs and queue the response expected in it.
  task automatic cycle(input out_t e, input string n, input logic mr, input logic z,
                       input logic rn, input logic [5:0] op);
    @(posedge clk);
    #1;
    mem_ready = mr;
    zero      = z;
    rst_n     = rn;
    opcode    = op;
    exp_q.push_back(e);
    name_q.push_back(n);
    cyc++;
  endtask

  // Instruction fetch: memory read at PC, PC+4 in the ALU; commit on ready.
  task automatic fetch(input logic [5:0] op, input int waits);
    out_t e;
    e = '0;
    e.st  = 4'd1;
    e.asb = 2'b01;
    for (int i = 0; i < waits; i++) cycle(e, "fetch_wait", 1'b0, rbit(), 1'b1, op);
    e.irw = 1'b1;
    e.pe  = 1'b1;
    cycle(e, "fetch_done", 1'b1, rbit(), 1'b1, op);
  endtask

  task automatic do_instr(input logic [5:0] op, input int fw, input int mw, input logic z);
    out_t e;
    fetch(op, fw);
    e = '0;
    e.st  = 4'd2;
    e.asb = 2'b11;
    e.ill = ~is_legal(op);
    cycle(e, "decode", rbit(), rbit(), 1'b1, op);
    case (op)
      OpLw, OpSw: begin
        e = '0;
        e.st  = 4'd3;
        e.asa = 1'b1;
        e.asb = 2'b10;
        cycle(e, "mem_addr", rbit(), rbit(), 1'b1, op);
        e = '0;
        e.iod = 1'b1;
        if (op == OpLw) begin
          e.st = 4'd4;
          for (int i = 0; i < mw; i++) cycle(e, "lw_read_wait", 1'b0, rbit(), 1'b1, op);
          cycle(e, "lw_read_done", 1'b1, rbit(), 1'b1, op);
          e = '0;
          e.st  = 4'd5;
          e.rw  = 1'b1;
          e.m2r = 1'b1;
          cycle(e, "lw_writeback", rbit(), rbit(), 1'b1, op);
        end else begin
          e.st = 4'd6;
          e.mw = 1'b1;
          for (int i = 0; i < mw; i++) cycle(e, "sw_write_wait", 1'b0, rbit(), 1'b1, op);
          cycle(e, "sw_write_done", 1'b1, rbit(), 1'b1, op);
        end
      end
      OpR: begin
        e = '0;
        e.st  = 4'd7;
        e.asa = 1'b1;
        e.aop = 2'd1;
        cycle(e, "rtype_exec", rbit(), rbit(), 1'b1, op);
        e = '0;
        e.st = 4'd8;
        e.rw = 1'b1;
        e.rd = 1'b1;
        cycle(e, "rtype_writeback", rbit(), rbit(), 1'b1, op);
      end
      OpBeq: begin
        e = '0;
        e.st  = 4'd9;
        e.asa = 1'b1;
        e.aop = 2'd2;
        e.pcs = 2'b01;
        e.pe  = z;
        cycle(e, "beq_branch", rbit(), z, 1'b1, op);
      end
`ifdef MC_CTRL_BNE_EN
      OpBne: begin
        e = '0;
        e.st  = 4'd13;
        e.asa = 1'b1;
        e.aop = 2'd2;
        e.pcs = 2'b01;
        e.pe  = ~z;
        cycle(e, "bne_branch", rbit(), z, 1'b1, op);
      end
`endif
      OpAddi: begin
        e = '0;
        e.st  = 4'd10;
        e.asa = 1'b1;
        e.asb = 2'b10;
        cycle(e, "addi_exec", rbit(), rbit(), 1'b1, op);
        e = '0;
        e.st = 4'd11;
        e.rw = 1'b1;
        cycle(e, "addi_writeback", rbit(), rbit(), 1'b1, op);
      end
      OpJ: begin
        e = '0;
        e.st  = 4'd12;
        e.pcs = 2'b10;
        e.pe  = 1'b1;
        cycle(e, "jump", rbit(), rbit(), 1'b1, op);
      end
      default: ; // illegal: decode returns straight to fetch
    endcase
  endtask

  task automatic reset_and_release(input int hold);
    out_t z0;
    z0 = '0;
    for (int i = 0; i < hold; i++) cycle(z0, "in_reset", rbit(), rbit(), 1'b0, opcode);
    cycle(z0, "idle_after_release", 1'b1, rbit(), 1'b1, opcode);
  endtask

  initial begin
    logic [5:0] ops [7];
    logic [5:0] op;
    int         fw, mw;
    out_t       e;
    ops = '{OpLw, OpSw, OpR, OpBeq, OpAddi, OpJ, OpBne};

    reset_and_release(3);
    do_instr(OpLw, 0, 0, 1'b0);

    // R-type interrupted by reset while in EXEC.
    fetch(OpR, 0);
    e = '0;
    e.st  = 4'd2;
    e.asb = 2'b11;
    cycle(e, "decode", 1'b1, 1'b0, 1'b1, OpR);
    e = '0;
    e.st  = 4'd7;
    e.asa = 1'b1;
    e.aop = 2'd1;
    cycle(e, "rtype_exec", 1'b1, 1'b0, 1'b1, OpR);
    #6;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_exec", act, '0);
    reset_and_release(2);

    do_instr(OpR, 3, 0, 1'b0);
    do_instr(OpSw, 3, 3, 1'b0);
    do_instr(OpBeq, 0, 0, 1'b1);
    do_instr(OpBeq, 0, 0, 1'b0);
    do_instr(OpJ, 0, 0, 1'b0);
    do_instr(6'b111111, 0, 0, 1'b0);
    do_instr(OpBne, 0, 0, 1'b0);
    do_instr(OpBne, 0, 0, 1'b1);
    do_instr(OpAddi, 1, 0, 1'b0);
    do_instr(OpLw, 2, 2, 1'b0);

    for (int n = 0; n < 100; n++) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
      else                           op = ops[$urandom_range(0, 6)];
      fw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      mw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      do_instr(op, fw, mw, rbit());
    end

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending responses required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
